mem_stage_unit: RTL and testbench

Memory-stage controller for the pipelined CPU, sitting directly downstream of the EX/MEM pipeline register and consuming its `*_m` outputs. It issues load and store accesses to a multi-cycle data memory over a req/ack handshake and stalls the front of the pipeline while an access is outstanding. It also produces the registered MEM/WB write-back fields (`*_w`) for the register file.

---
 rtl/mem_stage_unit_pkg.sv | 14 +
 rtl/mem_stage_unit_if.sv | 22 ++
 rtl/mem_stage_unit_timeout_ctr.sv | 30 +++
 rtl/mem_stage_unit.sv | 121 ++++++++++++
 tb/tb_mem_stage_unit.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_unit_pkg.sv
// Shared types and constants for the memory-stage controller.
package mem_stage_pkg;

  localparam int DATA_W      = 32;
  localparam int REG_W       = 5;
  localparam int LUI_SHIFT   = 16;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/mem_stage_unit_if.sv
// Data-memory req/ack bus between the memory stage (master) and the memory (slave).
interface mem_stage_unit_if;
  import mem_stage_pkg::*;

  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );

endinterface

// File: rtl/mem_stage_unit_timeout_ctr.sv
// Clear/enable cycle counter that flags the last permitted WAIT cycle.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // Count WAIT cycles without an ack; clear takes priority over enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/mem_stage_unit.sv
// Memory-stage controller: issues loads/stores over a req/ack bus, stalls the
// front of the pipeline while an access is outstanding, and registers the
// MEM/WB write-back fields.
module mem_stage_unit
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_write_m,
  input  logic              mem_to_reg_m,
  input  logic              mem_write_m,
  input  logic [DATA_W-1:0] alu_result_m,
  input  logic [DATA_W-1:0] write_data_m,
  input  logic [REG_W-1:0]  write_reg_m,
  input  logic              upper_m,
  mem_stage_unit_if.master  dmem,
  output logic              stall_m,
  output logic              reg_write_w,
  output logic [REG_W-1:0]  write_reg_w,
  output logic [DATA_W-1:0] result_w,
  output logic              bus_err
);

  state_t state;
  logic   mem_op;
  logic   misaligned;
  logic   expired;
  logic   ctr_clr;
  logic   ctr_en;

  // Non-memory write-back value: LUI-type results take the upper immediate.
  function automatic logic [DATA_W-1:0] alu_wb(input logic [DATA_W-1:0] v,
                                                input logic              up);
    return up ? (v << LUI_SHIFT) : v;
  endfunction

  assign mem_op     = mem_to_reg_m | mem_write_m;
  assign misaligned = |alu_result_m[1:0];

  // Stall while an aligned access is being launched or is still outstanding;
  // an ack or the final timeout cycle releases the pipeline.
  always_comb begin
    stall_m = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    stall_m = mem_op & ~misaligned;
        WAIT:    stall_m = ~dmem.ack & ~expired;
        default: stall_m = 1'b0;
      endcase
    end
  end

  // Counter is held at zero outside WAIT so every access starts from a clean count.
  assign ctr_clr = (state == IDLE);
  assign ctr_en  = (state == WAIT) & ~dmem.ack;

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk     (clk),
    .rst     (rst),
    .clr     (ctr_clr),
    .en      (ctr_en),
    .expired (expired)
  );

  // Access FSM with registered bus and write-back outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      dmem.req    <= 1'b0;
      dmem.we     <= 1'b0;
      dmem.addr   <= '0;
      dmem.wdata  <= '0;
      reg_write_w <= 1'b0;
      write_reg_w <= '0;
      result_w    <= '0;
      bus_err     <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!mem_op) begin
            reg_write_w <= reg_write_m;
            write_reg_w <= write_reg_m;
            result_w    <= alu_wb(alu_result_m, upper_m);
          end else if (misaligned) begin
            bus_err     <= 1'b1;
            reg_write_w <= 1'b0;
          end else begin
            dmem.req    <= 1'b1;
            dmem.we     <= mem_write_m;
            dmem.addr   <= alu_result_m;
            dmem.wdata  <= write_data_m;
            reg_write_w <= 1'b0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          // An ack on the last permitted cycle still completes the access.
          if (dmem.ack) begin
            dmem.req    <= 1'b0;
            reg_write_w <= reg_write_m;
            write_reg_w <= write_reg_m;
            result_w    <= mem_to_reg_m ? dmem.rdata : alu_result_m;
            state       <= IDLE;
          end else if (expired) begin
            dmem.req    <= 1'b0;
            bus_err     <= 1'b1;
            reg_write_w <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Scoreboard bench for mem_stage_unit: each instruction's expected write-back
// is queued when it is driven and compared when it retires from M.
module tb_mem_stage_unit;
  import mem_stage_pkg::*;

  localparam int TMO = 15;
  localparam int K_ALU = 0, K_LD = 1, K_ST = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reg_write_m, mem_to_reg_m, mem_write_m, upper_m;
  logic [31:0] alu_result_m, write_data_m;
  logic [4:0]  write_reg_m;
  logic        stall_m, reg_write_w, bus_err;
  logic [4:0]  write_reg_w;
  logic [31:0] result_w;

  mem_stage_unit_if dmem ();

  mem_stage_unit #(.TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .reg_write_m  (reg_write_m),
    .mem_to_reg_m (mem_to_reg_m),
    .mem_write_m  (mem_write_m),
    .alu_result_m (alu_result_m),
    .write_data_m (write_data_m),
    .write_reg_m  (write_reg_m),
    .upper_m      (upper_m),
    .dmem         (dmem.master),
    .stall_m      (stall_m),
    .reg_write_w  (reg_write_w),
    .write_reg_w  (write_reg_w),
    .result_w     (result_w),
    .bus_err      (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [4:0]  wreg;
    logic [31:0] res;
    logic        err;
    logic        data_ok;
    int          stalls;
    logic        req;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_nop();
    reg_write_m  = 1'b0;
    mem_to_reg_m = 1'b0;
    mem_write_m  = 1'b0;
    upper_m      = 1'b0;
    alu_result_m = '0;
    write_data_m = '0;
    write_reg_m  = '0;
  endtask

  // Called at posedge+1. ack_n: WAIT cycle on which ack is given (0 = never).
  task automatic run_op(input string name, input int kind, input logic [31:0] alu,
                        input logic [31:0] wd, input logic [4:0] wr, input logic rw,
                        input logic up, input int ack_n, input logic [31:0] rdata);
    exp_t e;
    exp_t got;
    int   stalls;
    int   waits;
    logic req_seen;
    logic memop;
    logic mis;
    memop  = (kind != K_ALU);
    mis    = memop && (alu[1:0] != 2'b00);
    e.req  = memop && !mis;
    e.wreg = wr;
    if (!memop) begin
      e.rw = rw; e.res = up ? {alu[15:0], 16'h0000} : alu;
      e.err = 1'b0; e.data_ok = 1'b1; e.stalls = 0;
    end else if (mis) begin
      e.rw = 1'b0; e.res = '0; e.err = 1'b1; e.data_ok = 1'b0; e.stalls = 0;
    end else if (ack_n == 0) begin
      e.rw = 1'b0; e.res = '0; e.err = 1'b1; e.data_ok = 1'b0; e.stalls = TMO;
    end else begin
      e.rw = rw; e.res = (kind == K_LD) ? rdata : alu;
      e.err = 1'b0; e.data_ok = 1'b1; e.stalls = ack_n;
    end
    sb.push_back(e);

    reg_write_m  = rw;
    mem_to_reg_m = (kind == K_LD);
    mem_write_m  = (kind == K_ST);
    upper_m      = up;
    alu_result_m = alu;
    write_data_m = wd;
    write_reg_m  = wr;
    dmem.ack     = 1'b0;
    dmem.rdata   = 32'hBAD0_BAD0;
    stalls   = 0;
    waits    = 0;
    req_seen = 1'b0;
    #1;
    while (stall_m && stalls < 3 * TMO) begin
      stalls++;
      @(posedge clk); #1;
      waits++;
      req_seen |= dmem.req;
      chk({name, "_addr_hold"}, dmem.addr, alu);
      if (waits == 1) begin
        chk({name, "_we"}, {31'd0, dmem.we}, {31'd0, kind == K_ST});
        if (kind == K_ST) chk({name, "_wdata"}, dmem.wdata, wd);
      end
      if (waits == ack_n) begin
        dmem.ack   = 1'b1;
        dmem.rdata = rdata;
      end
      #1;
    end
    @(posedge clk); #1;
    dmem.ack   = 1'b0;
    dmem.rdata = 32'hBAD0_BAD0;
    got = sb.pop_front();
    chk({name, "_stalls"}, stalls, got.stalls);
    chk({name, "_req_seen"}, {31'd0, req_seen}, {31'd0, got.req});
    chk({name, "_req_after"}, {31'd0, dmem.req}, 32'd0);
    chk({name, "_bus_err"}, {31'd0, bus_err}, {31'd0, got.err});
    chk({name, "_reg_write_w"}, {31'd0, reg_write_w}, {31'd0, got.rw});
    if (got.data_ok) begin
      chk({name, "_write_reg_w"}, {27'd0, write_reg_w}, {27'd0, got.wreg});
      chk({name, "_result_w"}, result_w, got.res);
    end
    drive_nop();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    drive_nop();
    dmem.ack   = 1'b0;
    dmem.rdata = '0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, dmem.req}, 32'd0);
    chk("rst_stall", {31'd0, stall_m}, 32'd0);
    chk("rst_reg_write_w", {31'd0, reg_write_w}, 32'd0);
    chk("rst_result_w", result_w, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    rst = 1'b0;

    run_op("alu",    K_ALU, 32'h0000_1234, 32'h0, 5'd8,  1'b1, 1'b0, 0, 32'h0);
    run_op("lui",    K_ALU, 32'h0000_ABCD, 32'h0, 5'd3,  1'b1, 1'b1, 0, 32'h0);
    run_op("load",   K_LD,  32'h0000_0040, 32'h0, 5'd9,  1'b1, 1'b0, 4, 32'hDEAD_BEEF);
    run_op("store",  K_ST,  32'h0000_0080, 32'h55, 5'd0, 1'b0, 1'b0, 1, 32'h0);
    run_op("misal",  K_LD,  32'h0000_0042, 32'h0, 5'd4,  1'b1, 1'b0, 1, 32'h1111_1111);
    run_op("after_misal", K_ALU, 32'h0000_0777, 32'h0, 5'd5, 1'b1, 1'b0, 0, 32'h0);
    run_op("timeout", K_LD, 32'h0000_0100, 32'h0, 5'd6,  1'b1, 1'b0, 0, 32'h0);
    run_op("after_tmo", K_ALU, 32'h0000_0999, 32'h0, 5'd7, 1'b1, 1'b0, 0, 32'h0);
    run_op("ack_last", K_LD, 32'h0000_0200, 32'h0, 5'd10, 1'b1, 1'b0, TMO, 32'hCAFE_F00D);

    for (int i = 0; i < 6; i++) begin
      int          k;
      logic [31:0] a;
      k = $urandom_range(0, 2);
      a = {$urandom_range(0, 16'hFFFF), 2'b00} & 32'h0003_FFFC;
      run_op("rand", k, a, $urandom, 5'($urandom_range(1, 31)),
             (k == K_ST) ? 1'b0 : 1'b1, 1'b0, $urandom_range(1, 4), $urandom);
    end

    run_op("pre_rst", K_ALU, 32'h0000_5A5A, 32'h0, 5'd12, 1'b1, 1'b0, 0, 32'h0);
    reg_write_m  = 1'b1;
    mem_to_reg_m = 1'b1;
    alu_result_m = 32'h0000_0300;
    write_reg_m  = 5'd13;
    @(posedge clk); #1;
    chk("midwait_req", {31'd0, dmem.req}, 32'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_req", {31'd0, dmem.req}, 32'd0);
    chk("arst_stall", {31'd0, stall_m}, 32'd0);
    chk("arst_reg_write_w", {31'd0, reg_write_w}, 32'd0);
    chk("arst_write_reg_w", {27'd0, write_reg_w}, 32'd0);
    chk("arst_result_w", result_w, 32'd0);
    chk("arst_bus_err", {31'd0, bus_err}, 32'd0);
    drive_nop();
    @(posedge clk); #1;
    rst = 1'b0;
    run_op("post_rst_load", K_LD, 32'h0000_0400, 32'h0, 5'd14, 1'b1, 1'b0, 2, 32'h0BAD_CAFE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
